// File: rtl/om_pkg.sv
// Shared constants for the online-multiplier selection stages.
// This package holds the digit codes, the FSM encoding and the selection thresholds.
package om_pkg;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Estimate thresholds, in units of 1/4
  localparam logic signed [3:0] SEL_HI = 4'sd2;
  localparam logic signed [3:0] SEL_LO = -4'sd3;

  function automatic int cnt_width(input int n, input int d);
    int m;
    m = (n > d) ? n : d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/om_sel_stage_if.sv
// Residual in / digit-and-residual out bundle of one selection stage.
interface om_sel_stage_if;
  logic       in_valid;
  logic [6:0] Ws_in;
  logic [6:0] Wc_in;
  logic [1:0] z;
  logic       z_valid;
  logic [5:0] Ws_out;
  logic [5:0] Wc_out;

  modport master (output in_valid, Ws_in, Wc_in, input z, z_valid, Ws_out, Wc_out);
  modport slave  (input in_valid, Ws_in, Wc_in, output z, z_valid, Ws_out, Wc_out);
endinterface

// File: rtl/om_sel.sv
// Digit selection from the 4-bit residual estimate (sum of top fields, units of 1/4).
module om_sel
  import om_pkg::*;
(
  input  logic [3:0] ws_hi_i,
  input  logic [3:0] wc_hi_i,
  output logic [1:0] z_o
);

  logic signed [3:0] v;

  assign v = ws_hi_i + wc_hi_i;

  always_comb begin
    if (v >= SEL_HI) begin
      z_o = DIG_POS;
    end else if (v <= SEL_LO) begin
      z_o = DIG_NEG;
    end else begin
      z_o = DIG_ZERO;
    end
  end

endmodule

// File: rtl/om_sel_stage.sv
// Online-multiplier selection stage: DELTA warm-up iterations, then N registered
// product digits with the shifted residual forwarded to the next iteration.
module om_sel_stage
  import om_pkg::*;
#(
  parameter int N     = 8,
  parameter int DELTA = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  om_sel_stage_if.slave  bus,
  output logic           busy,
  output logic           done
);

  localparam int CW = cnt_width(N, DELTA);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    z_q, z_d;
  logic          zv_q, zv_d;
  logic [5:0]    ws_q, ws_d;
  logic [5:0]    wc_q, wc_d;
  logic [1:0]    z_sel;
  logic [6:0]    w_mod;

  om_sel u_sel (
    .ws_hi_i (bus.Ws_in[6:3]),
    .wc_hi_i (bus.Wc_in[6:3]),
    .z_o     (z_sel)
  );

  // Remove the selected digit at weight 2^5; bit6 is dropped afterwards for the x2 shift
  always_comb begin
    case (z_sel)
      DIG_POS: w_mod = bus.Ws_in - 7'b0100000;
      DIG_NEG: w_mod = bus.Ws_in + 7'b0100000;
      default: w_mod = bus.Ws_in;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    zv_d    = 1'b0;
    ws_d    = ws_q;
    wc_d    = wc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      ST_INIT: begin
        if (bus.in_valid) begin
          z_d  = DIG_ZERO;
          ws_d = bus.Ws_in[5:0];
          wc_d = bus.Wc_in[5:0];
          if (cnt_q == CW'(DELTA - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_RUN: begin
        if (bus.in_valid) begin
          z_d  = z_sel;
          zv_d = 1'b1;
          ws_d = w_mod[5:0];
          wc_d = bus.Wc_in[5:0];
          if (cnt_q == CW'(N - 1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      z_q     <= DIG_ZERO;
      zv_q    <= 1'b0;
      ws_q    <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      zv_q    <= zv_d;
      ws_q    <= ws_d;
      wc_q    <= wc_d;
    end
  end

  assign bus.z       = z_q;
  assign bus.z_valid = zv_q;
  assign bus.Ws_out  = ws_q;
  assign bus.Wc_out  = wc_q;
  assign busy        = (state_q == ST_INIT) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_om_sel_stage.sv
// Bench for om_sel_stage: randomized residuals against an arithmetic reference model,
// plus directed digit vectors, a mid-RUN stall, start-in-RUN and a mid-operation reset.
module tb_om_sel_stage;

  localparam int N     = 8;
  localparam int DELTA = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  om_sel_stage_if bus ();

  om_sel_stage #(.N(N), .DELTA(DELTA)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_fail    = 0;
  int zv_seen   = 0;
  int done_seen = 0;

  // Reference model: phases expressed as remaining work
  int         init_left;
  int         run_left;
  bit         done_pend;
  logic [1:0] exp_z;
  logic       exp_zv;
  logic [5:0] exp_ws;
  logic [5:0] exp_wc;

  logic [6:0] dir_ws  [4] = '{7'b0010000, 7'b1101000, 7'b0001000, 7'b0001000};
  logic [6:0] dir_wc  [4] = '{7'b0000000, 7'b0000000, 7'b0001000, 7'b0000000};
  logic [1:0] dir_z   [4] = '{2'b10, 2'b01, 2'b10, 2'b00};
  logic [5:0] dir_wso [4] = '{6'b110000, 6'b001000, 6'b101000, 6'b001000};
  logic [5:0] dir_wco [4] = '{6'b000000, 6'b000000, 6'b001000, 6'b000000};

  function automatic int field(input logic [6:0] w);
    int f;
    f = int'(w[6:3]);
    if (f >= 8) f -= 16;
    return f;
  endfunction

  function automatic int select_digit(input logic [6:0] ws, input logic [6:0] wc);
    int v;
    v = field(ws) + field(wc);
    if (v > 7) v -= 16;
    else if (v < -8) v += 16;
    if (v >= 2) return 1;
    if (v <= -3) return -1;
    return 0;
  endfunction

  task automatic model_reset();
    init_left = 0;
    run_left  = 0;
    done_pend = 1'b0;
    exp_z     = 2'b00;
    exp_zv    = 1'b0;
    exp_ws    = 6'd0;
    exp_wc    = 6'd0;
  endtask

  task automatic model_edge();
    int d;
    int r;
    logic [6:0] t;
    if (rst) begin
      model_reset();
      return;
    end
    exp_zv = 1'b0;
    if (done_pend) begin
      done_pend = 1'b0;
    end else if (init_left > 0) begin
      if (bus.in_valid) begin
        exp_z  = 2'b00;
        exp_ws = bus.Ws_in[5:0];
        exp_wc = bus.Wc_in[5:0];
        init_left--;
        if (init_left == 0) run_left = N;
      end
    end else if (run_left > 0) begin
      if (bus.in_valid) begin
        d      = select_digit(bus.Ws_in, bus.Wc_in);
        exp_z  = (d == 1) ? 2'b10 : (d == -1) ? 2'b01 : 2'b00;
        exp_zv = 1'b1;
        r      = int'(bus.Ws_in) - d * 32;
        r      = ((r % 128) + 128) % 128;
        t      = 7'(r);
        exp_ws = t[5:0];
        exp_wc = bus.Wc_in[5:0];
        run_left--;
        if (run_left == 0) done_pend = 1'b1;
      end
    end else if (start) begin
      init_left = DELTA;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("z",       32'(bus.z),       32'(exp_z));
    check("z_valid", 32'(bus.z_valid), 32'(exp_zv));
    check("Ws_out",  32'(bus.Ws_out),  32'(exp_ws));
    check("Wc_out",  32'(bus.Wc_out),  32'(exp_wc));
    check("busy",    32'(busy),        32'((init_left > 0) || (run_left > 0)));
    check("done",    32'(done),        32'(done_pend));
    if (bus.z_valid === 1'b1) zv_seen++;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive_rand();
    bus.Ws_in = 7'($urandom);
    bus.Wc_in = 7'($urandom);
  endtask

  task automatic do_reset();
    start = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    rst = 1'b0;
    bus.in_valid = 1'($urandom);
    drive_rand();
    step();
  endtask

  task automatic run_op(input bit directed, input bit gap, input bit hold_start,
                        input int abort_after, input int valid_pct);
    int zv0;
    int dn0;
    int steps;
    int gap_left;
    int idx;
    bit aborted;
    zv0      = zv_seen;
    dn0      = done_seen;
    gap_left = gap ? 2 : 0;
    aborted  = 1'b0;
    steps    = 0;
    start        = 1'b1;
    bus.in_valid = 1'($urandom);
    drive_rand();
    step();
    start = hold_start;
    while ((init_left > 0 || run_left > 0) && steps < 100) begin
      idx = (run_left > 0) ? (N - run_left) : -1;
      if (abort_after > 0 && idx == abort_after) begin
        do_reset();
        aborted = 1'b1;
        break;
      end
      bus.in_valid = ($urandom_range(99) < valid_pct);
      drive_rand();
      if (gap && idx == 4 && gap_left > 0) begin
        bus.in_valid = 1'b0;
        gap_left--;
      end
      if (directed && idx >= 0 && idx < 4) begin
        bus.in_valid = 1'b1;
        bus.Ws_in    = dir_ws[idx];
        bus.Wc_in    = dir_wc[idx];
      end
      step();
      if (directed && idx >= 0 && idx < 4) begin
        check("dir_z",      32'(bus.z),       32'(dir_z[idx]));
        check("dir_zvalid", 32'(bus.z_valid), 32'(1));
        check("dir_Ws_out", 32'(bus.Ws_out),  32'(dir_wso[idx]));
        check("dir_Wc_out", 32'(bus.Wc_out),  32'(dir_wco[idx]));
      end
      steps++;
    end
    check("op_within_budget", 32'(steps < 100), 32'(1));
    start = 1'b0;
    if (aborted) begin
      check("digits_before_abort", 32'(zv_seen - zv0), 32'(abort_after));
    end else begin
      bus.in_valid = 1'b1;
      drive_rand();
      step();
      check("digit_count", 32'(zv_seen - zv0), 32'(N));
      check("done_count",  32'(done_seen - dn0), 32'(1));
    end
    $display("op directed=%0d gap=%0d hold_start=%0d abort=%0d digits=%0d done=%0d",
             directed, gap, hold_start, abort_after, zv_seen - zv0, done_seen - dn0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.Ws_in    = 7'd0;
    bus.Wc_in    = 7'd0;
    model_reset();
    #2;
    check_all();
    step();
    rst = 1'b0;
    // in_valid while idle must not disturb the outputs
    repeat (4) begin
      bus.in_valid = 1'b1;
      drive_rand();
      step();
    end
    run_op(1'b1, 1'b1, 1'b0, 0, 100);
    run_op(1'b0, 1'b0, 1'b1, 0, 80);
    run_op(1'b0, 1'b0, 1'b0, 5, 75);
    run_op(1'b0, 1'b0, 1'b0, 0, 100);
    repeat (6) run_op(1'b0, 1'b0, 1'($urandom_range(1)), 0, 60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
